ack_parser: RTL
===============

# ack_parser

Receive-side decoder for the `ACK <n>\n` command line emitted by `ack_generator`. It consumes the byte stream from a `uart_rx` (`data`/`valid`), validates the line syntax and converts the decimal argument to binary. It presents the result as a one-cycle `ack_valid` pulse with a held `ack_value`. It sits between `uart_rx` and the super counter's command logic and can also serve as a bench-side checker of generated ACK traffic.

## Interface
- `VALUE_W`, default 16: width of the decoded value.
- `MAX_DIGITS`, default 5: maximum decimal digits accepted, leading zeros included.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received byte; sampled only when `rx_valid`=1.
- `rx_valid`  in  1: one-cycle strobe, one byte per strobe.
- `ack_value`  out  VALUE_W: last successfully decoded argument; held until the next success.
- `ack_valid`  out  1: one-cycle pulse marking a complete, well-formed line.
- `parse_error`  out  1: one-cycle pulse marking a malformed line.
- `busy`  out  1: high while a line is partially received, i.e. state ≠ S_IDLE.

## Operation
- State is only examined and advanced on cycles where `rx_valid`=1; otherwise all state holds.
- States and transitions:
  - S_IDLE: on 'A' (0x41), go to S_A. Any byte other than 0x0A: error, go to S_DISCARD. A bare 0x0A is ignored, so empty lines are silent.
  - S_A: on 'C' (0x43), go to S_C.
  - S_C: on 'K' (0x4B), go to S_K.
  - S_K: on ' ' (0x20), clear the accumulator and digit count, then go to S_DIGITS.
  - S_DIGITS, on '0'–'9':
    - Compute acc = acc*10 + digit, using VALUE_W+4 bits internally.
    - Increment the digit count.
    - Error if the count would exceed MAX_DIGITS or the result exceeds 2^VALUE_W−1.
  - S_DIGITS, on 0x0A: with count ≥1, load `ack_value` and pulse `ack_valid`; with count 0, error. Either way go to S_IDLE.
  - S_DISCARD: ignore every byte until 0x0A, then go to S_IDLE with no additional pulse.
- Error on a non-newline byte: pulse `parse_error` and go to S_DISCARD.
- Error on 0x0A received in S_A, S_C, S_K, or S_DIGITS with zero digits: pulse `parse_error` and go directly to S_IDLE.
- Only one of `ack_valid` and `parse_error` pulses per line. `ack_value` is never modified by an error.
- Leading zeros are legal ("ACK 007\n" → 7) and count toward MAX_DIGITS.

## Timing
- Latency: `ack_valid` or `parse_error` is registered and asserts the cycle after the `rx_valid` cycle that carried the deciding byte.
- Throughput: back-to-back `rx_valid` on consecutive cycles is supported; no byte is dropped.
- Reset values: `ack_value`=0, `ack_valid`=0, `parse_error`=0, `busy`=0, state S_IDLE, accumulator and count 0.
- Reset mid-line discards the partial line with no pulse. The first byte after reset is parsed as a line start.
- `rst` and `rx_valid` asserted in the same cycle: reset wins and the byte is lost.
- Boundaries, with default parameters:
  - "ACK 65535\n" is accepted.
  - "ACK 65536\n" raises the error on the final '6', then the line is discarded.
  - "ACK 000001\n" raises the error on the 6th digit.

## Configuration
- `ACK_PARSER_CR_EN` defined:
  - In S_DIGITS, a 0x0D with count ≥1 moves to S_CR.
  - S_CR accepts only 0x0A, which is treated exactly as a newline in S_DIGITS.
  - Any other byte in S_CR is an error and goes to S_DISCARD.
  - In S_DISCARD, 0x0D is ignored like any other byte.
- `ACK_PARSER_CR_EN` undefined: S_CR is absent, and 0x0D in S_DIGITS is an error (go to S_DISCARD).

## Structure
- Shared package `ack_proto_pkg`:
  - `ack_state_t` enum, including S_CR under the macro.
  - ASCII constants `ASC_A`, `ASC_C`, `ASC_K`, `ASC_SP`, `ASC_LF`, `ASC_CR`.
  - This package is shared with `ack_generator`, so both ends use one message definition.
- One sub-module, `dec_digit_accum`:
  - Inputs: clear, digit strobe, 4-bit digit.
  - Outputs: acc, digit count, overflow flag.
  - Holds the multiply-by-10 arithmetic (shift-add: acc<<3 + acc<<1 + digit) and the MAX_DIGITS / VALUE_W checks.
- FSM and output registers stay in `ack_parser`.

## Test plan
- Send "ACK 100\n", bytes on every 4th cycle → `ack_valid` pulses 1 cycle after the LF; `ack_value`=100; `parse_error` never asserts; `busy`=0 afterwards.
- Send "ACK 65535\n" back-to-back, then "ACK 65536\n" → first gives value 65535. Second gives `parse_error` 1 cycle after the final '6', no `ack_valid`, and `ack_value` stays 65535.
- Send "ACX 5\n" then "ACK 7\n" → `parse_error` after 'X', the rest of the first line is discarded, then `ack_valid` with value 7.
- Send "ACK \n" and "AC\n" → each gives a single `parse_error` on the LF; the state returns to S_IDLE.
- Send "ACK 12", assert `rst` for 1 cycle, then send "ACK 3\n" → no pulse from the partial line; value 3 is decoded.
- Send "ACK 42\r\n": with `ACK_PARSER_CR_EN` → `ack_valid`, value 42. Without it → `parse_error` on the CR and no `ack_valid`.

Source files
------------

// File: rtl/ack_proto_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ack_proto_pkg
// Description : Shared "ACK <n>\n" message definition (states, ASCII codes).
//               ACK_PARSER_CR_EN adds the S_CR state for CR-LF terminated lines.
// Revision    : 1.0 - initial release
// ============================================================================
package ack_proto_pkg;

    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_C  = 8'h43;
    localparam logic [7:0] ASC_K  = 8'h4B;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_A       = 3'd1,
        S_C       = 3'd2,
        S_K       = 3'd3,
        S_DIGITS  = 3'd4,
        S_DISCARD = 3'd5
`ifdef ACK_PARSER_CR_EN
        ,
        S_CR      = 3'd6
`endif
    } ack_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_digit_accum.sv
`default_nettype none
// ============================================================================
// Module      : dec_digit_accum
// Description : Decimal accumulator (acc*10 + digit) with digit-count and
//               value-range limits; overflow reflects the digit on the input.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_digit_accum #(
    parameter int VALUE_W    = 16,
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_digit_stb,
    input  logic [3:0]         i_digit,
    output logic [VALUE_W-1:0] o_acc,
    output logic [CNT_W-1:0]   o_digit_count,
    output logic               o_overflow
);

    localparam int               c_wide_w  = VALUE_W + 4;
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DIGITS);

    logic [VALUE_W-1:0]  r_acc;
    logic [CNT_W-1:0]    r_count;
    logic [c_wide_w-1:0] w_acc_wide;
    logic [c_wide_w-1:0] w_next_wide;

    // Four guard bits hold acc*10+9 for any in-range acc, so the top nibble flags overflow.
    assign w_acc_wide  = {4'b0000, r_acc};
    assign w_next_wide = (w_acc_wide << 3) + (w_acc_wide << 1) + {{VALUE_W{1'b0}}, i_digit};
    assign o_overflow  = (r_count >= c_max_cnt) || (w_next_wide[c_wide_w-1:VALUE_W] != 4'b0000);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_digit_stb && !o_overflow) begin
            r_acc   <= w_next_wide[VALUE_W-1:0];
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_acc         = r_acc;
    assign o_digit_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ack_parser.sv
`default_nettype none
// ============================================================================
// Module      : ack_parser
// Description : Parses "ACK <n>\n" lines from a UART byte stream into a value.
//               Define ACK_PARSER_CR_EN to also accept "ACK <n>\r\n".
// Revision    : 1.0 - initial release
// ============================================================================
module ack_parser #(
    parameter int VALUE_W    = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [VALUE_W-1:0] ack_value,
    output logic               ack_valid,
    output logic               parse_error,
    output logic               busy
);

    import ack_proto_pkg::*;

    localparam int c_cnt_w = $clog2(MAX_DIGITS + 1);

    ack_state_t         r_state;
    ack_state_t         w_state_next;
    logic [VALUE_W-1:0] r_ack_value;
    logic               r_ack_valid;
    logic               r_parse_error;

    logic               w_ack;
    logic               w_err;
    logic               w_clear;
    logic               w_stb;
    logic [VALUE_W-1:0] w_acc;
    logic [c_cnt_w-1:0] w_count;
    logic               w_overflow;

    dec_digit_accum #(
        .VALUE_W    (VALUE_W),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (c_cnt_w)
    ) u_accum (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_clear),
        .i_digit_stb   (w_stb),
        .i_digit       (rx_data[3:0]),
        .o_acc         (w_acc),
        .o_digit_count (w_count),
        .o_overflow    (w_overflow)
    );

    always_comb begin
        w_state_next = r_state;
        w_ack        = 1'b0;
        w_err        = 1'b0;
        w_clear      = 1'b0;
        w_stb        = 1'b0;
        if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == ASC_A) begin
                        w_state_next = S_A;
                    end else if (rx_data != ASC_LF) begin
                        w_err        = 1'b1;
                        w_state_next = S_DISCARD;
                    end
                end
                S_A: begin
                    if (rx_data == ASC_C) begin
                        w_state_next = S_C;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = (rx_data == ASC_LF) ? S_IDLE : S_DISCARD;
                    end
                end
                S_C: begin
                    if (rx_data == ASC_K) begin
                        w_state_next = S_K;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = (rx_data == ASC_LF) ? S_IDLE : S_DISCARD;
                    end
                end
                S_K: begin
                    if (rx_data == ASC_SP) begin
                        w_clear      = 1'b1;
                        w_state_next = S_DIGITS;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = (rx_data == ASC_LF) ? S_IDLE : S_DISCARD;
                    end
                end
                S_DIGITS: begin
                    if (is_digit(rx_data)) begin
                        if (w_overflow) begin
                            w_err        = 1'b1;
                            w_state_next = S_DISCARD;
                        end else begin
                            w_stb        = 1'b1;
                        end
                    end else if (rx_data == ASC_LF) begin
                        w_ack        = (w_count != '0);
                        w_err        = (w_count == '0);
                        w_state_next = S_IDLE;
`ifdef ACK_PARSER_CR_EN
                    end else if ((rx_data == ASC_CR) && (w_count != '0)) begin
                        w_state_next = S_CR;
`endif
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = S_DISCARD;
                    end
                end
`ifdef ACK_PARSER_CR_EN
                S_CR: begin
                    // Entry required at least one digit, so LF here always succeeds.
                    if (rx_data == ASC_LF) begin
                        w_ack        = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = S_DISCARD;
                    end
                end
`endif
                S_DISCARD: begin
                    if (rx_data == ASC_LF) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ack_value   <= '0;
            r_ack_valid   <= 1'b0;
            r_parse_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ack_valid   <= w_ack;
            r_parse_error <= w_err;
            if (w_ack) begin
                r_ack_value <= w_acc;
            end
        end
    end

    assign ack_value   = r_ack_value;
    assign ack_valid   = r_ack_valid;
    assign parse_error = r_parse_error;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
